// File: rtl/tick_mon_pkg.sv
// Shared widths, FSM encoding and helpers for the tick monitor.
package tick_mon_pkg;

    localparam int CNT_W  = 32;
    localparam int FCNT_W = 8;
    localparam int MISS_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } tick_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/tick_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module tick_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tick_monitor.sv
// Tick period monitor: measures tick interval, flags early/late ticks, drops alive on loss.
// Define TICK_MON_STATS_EN to add period_min/period_max outputs.
module tick_monitor
    import tick_mon_pkg::*;
#(
    parameter int unsigned PERIOD_NOM = 100001,
    parameter int unsigned PERIOD_TOL = 500,
    parameter int unsigned MISS_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_in,
    input  logic              clear_fault,
    output logic [CNT_W-1:0]  period_out,
    output logic              period_valid,
    output logic              early_err,
    output logic              late_err,
    output logic [FCNT_W-1:0] fault_cnt,
    output logic              alive
`ifdef TICK_MON_STATS_EN
    ,
    output logic [CNT_W-1:0]  period_min,
    output logic [CNT_W-1:0]  period_max
`endif
);

    localparam logic [CNT_W-1:0]  EARLY_TH   = CNT_W'(PERIOD_NOM - PERIOD_TOL);
    localparam logic [CNT_W-1:0]  WIN_LAST   = CNT_W'(PERIOD_NOM + PERIOD_TOL - 1);
    localparam logic [CNT_W-1:0]  WIN_RELOAD = CNT_W'(PERIOD_TOL);
    localparam logic [MISS_W-1:0] MISS_LAST  = MISS_W'(MISS_LIMIT - 1);

    tick_state_e       state_q, state_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              pv_q, pv_d;
    logic              early_q, early_d;
    logic              late_q, late_d;
    logic              alive_q, alive_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  meas;

    // cnt restarts on every tick and on clear; it keeps counting in every state.
    tick_sat_cnt #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_in | clear_fault),
        .inc   (1'b1),
        .q     (cnt_q)
    );

    tick_sat_cnt #(.W(FCNT_W)) u_fault_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear_fault),
        .inc   (early_d | late_d),
        .q     (fault_cnt)
    );

    assign meas = sat_inc(cnt_q);

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        miss_d   = miss_q;
        period_d = period_q;
        pv_d     = 1'b0;
        early_d  = 1'b0;
        late_d   = 1'b0;

        if (clear_fault) begin
            state_d = ST_IDLE;
            wcnt_d  = '0;
            miss_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick_in) begin
                        state_d = ST_RUN;
                        wcnt_d  = '0;
                        miss_d  = '0;
                    end
                end
                ST_RUN: begin
                    if (tick_in) begin
                        period_d = meas;
                        pv_d     = 1'b1;
                        // A tick that closes a missed window is late, never early.
                        early_d  = (miss_q == '0) && (meas < EARLY_TH);
                        wcnt_d   = '0;
                        miss_d   = '0;
                    end else if (wcnt_q == WIN_LAST) begin
                        late_d = 1'b1;
                        wcnt_d = WIN_RELOAD;
                        miss_d = miss_q + MISS_W'(1);
                        if (miss_q == MISS_LAST) begin
                            state_d = ST_DEAD;
                        end
                    end else begin
                        wcnt_d = wcnt_q + CNT_W'(1);
                    end
                end
                ST_DEAD: begin
                    if (tick_in) begin
                        period_d = meas;
                        pv_d     = 1'b1;
                        state_d  = ST_RUN;
                        wcnt_d   = '0;
                        miss_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        alive_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= '0;
            miss_q   <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            early_q  <= 1'b0;
            late_q   <= 1'b0;
            alive_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            miss_q   <= miss_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            early_q  <= early_d;
            late_q   <= late_d;
            alive_q  <= alive_d;
        end
    end

    assign period_out   = period_q;
    assign period_valid = pv_q;
    assign early_err    = early_q;
    assign late_err     = late_q;
    assign alive        = alive_q;

`ifdef TICK_MON_STATS_EN
    logic [CNT_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] max_q, max_d;

    // Only in-service periods are tracked; the gap that ends DEAD is not.
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (clear_fault) begin
            min_d = '1;
            max_d = '0;
        end else if ((state_q == ST_RUN) && tick_in) begin
            if (meas < min_q) min_d = meas;
            if (meas > max_q) max_d = meas;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign period_min = min_q;
    assign period_max = max_q;
`endif

endmodule

// File: tb/tb_tick_monitor.sv
// Self-checking bench for tick_monitor: directed table, corner sequences, random gaps.
module tb_tick_monitor;

    localparam int NOM = 100;
    localparam int TOL = 5;
    localparam int LIM = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_in = 1'b0;
    logic        clear_fault = 1'b0;
    logic [31:0] period_out;
    logic        period_valid;
    logic        early_err;
    logic        late_err;
    logic [7:0]  fault_cnt;
    logic        alive;
`ifdef TICK_MON_STATS_EN
    logic [31:0] period_min;
    logic [31:0] period_max;
`endif

    tick_monitor #(
        .PERIOD_NOM (NOM),
        .PERIOD_TOL (TOL),
        .MISS_LIMIT (LIM)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_in      (tick_in),
        .clear_fault  (clear_fault),
        .period_out   (period_out),
        .period_valid (period_valid),
        .early_err    (early_err),
        .late_err     (late_err),
        .fault_cnt    (fault_cnt),
        .alive        (alive)
`ifdef TICK_MON_STATS_EN
        ,
        .period_min   (period_min),
        .period_max   (period_max)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: absolute edge index, last time cnt was zeroed, next late deadline.
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DEAD = 2;
    int          n = 0;
    int          mode;
    int          last_zero;
    int          deadline;
    int          misses;
    int          m_fault;
    logic [31:0] m_period;
    logic        m_pv, m_early, m_late;
    logic [31:0] m_min, m_max;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mode = M_IDLE; m_fault = 0; misses = 0; m_period = 0;
        m_pv = 0; m_early = 0; m_late = 0;
        last_zero = n - 1; deadline = -1;
        m_min = 32'hFFFF_FFFF; m_max = 0;
    endtask

    task automatic fault_inc();
        if (m_fault < 255) m_fault++;
    endtask

    task automatic model_edge(input bit t, input bit c);
        int per;
        m_pv = 0; m_early = 0; m_late = 0;
        if (c) begin
            mode = M_IDLE; m_fault = 0; misses = 0; last_zero = n;
            m_min = 32'hFFFF_FFFF; m_max = 0;
        end else if (t) begin
            per = n - last_zero;
            if (mode == M_RUN) begin
                m_pv = 1; m_period = per;
                if (misses == 0 && per < NOM - TOL) begin
                    m_early = 1; fault_inc();
                end
                if (per < m_min) m_min = per;
                if (per > m_max) m_max = per;
            end else if (mode == M_DEAD) begin
                m_pv = 1; m_period = per;
            end
            mode = M_RUN; misses = 0; deadline = n + NOM + TOL; last_zero = n;
        end else if (mode == M_RUN && n == deadline) begin
            m_late = 1; fault_inc(); misses++; deadline = n + NOM;
            if (misses == LIM) mode = M_DEAD;
        end
        n++;
    endtask

    task automatic check_outputs();
        logic [7:0] ef;
        ef = m_fault[7:0];
        check($sformatf("cyc%0d", n),
              {20'd0, period_valid, early_err, late_err, alive, fault_cnt, period_out},
              {20'd0, m_pv, m_early, m_late, (mode == M_RUN), ef, m_period});
`ifdef TICK_MON_STATS_EN
        check($sformatf("stats_cyc%0d", n), {period_min, period_max}, {m_min, m_max});
`endif
    endtask

    task automatic step(input bit t, input bit c);
        tick_in = t; clear_fault = c;
        @(posedge clk);
        model_edge(t, c);
        #1;
        tick_in = 0; clear_fault = 0;
        check_outputs();
    endtask

    task automatic gap_tick(input int gap);
        repeat (gap - 1) step(0, 0);
        step(1, 0);
    endtask

    typedef struct {
        int gap;
        bit pv;
        int period;
        bit early;
        int fault;
    } vec_t;

    vec_t tbl[$];
    int   nlate;
    int   g;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1);
    end

    initial begin
        tbl.push_back('{10, 0, 0, 0, 0});
        for (int i = 0; i < 9; i++) tbl.push_back('{100, 1, 100, 0, 0});
        tbl.push_back('{90, 1, 90, 1, 1});
        tbl.push_back('{95, 1, 95, 0, 1});
        tbl.push_back('{105, 1, 105, 0, 1});
        tbl.push_back('{94, 1, 94, 1, 2});
        tbl.push_back('{106, 1, 106, 0, 3});

        // Reset state
        #23;
        check("rst_period", period_out, 0);
        check("rst_flags", {period_valid, early_err, late_err, alive}, 4'b0000);
        check("rst_fault", fault_cnt, 0);
`ifdef TICK_MON_STATS_EN
        check("rst_min", period_min, 32'hFFFF_FFFF);
        check("rst_max", period_max, 0);
`endif
        #4 rst_n = 1'b1;
        n = 0;
        model_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            gap_tick(tbl[i].gap);
            check($sformatf("tbl%0d_pv", i), period_valid, tbl[i].pv);
            if (tbl[i].pv) check($sformatf("tbl%0d_period", i), period_out, tbl[i].period);
            check($sformatf("tbl%0d_early", i), early_err, tbl[i].early);
            check($sformatf("tbl%0d_fault", i), fault_cnt, tbl[i].fault);
            check($sformatf("tbl%0d_alive", i), alive, 1);
        end

        // Tick loss: three late windows, then DEAD
        nlate = 0;
        for (int k = 0; k < 310; k++) begin
            step(0, 0);
            if (late_err) nlate++;
        end
        check("late_count", nlate, 3);
        check("dead_alive", alive, 0);
        check("dead_fault", fault_cnt, 6);
        repeat (89) step(0, 0);
        step(1, 0);
        check("recover_period", period_out, 400);
        check("recover_pv_early", {period_valid, early_err}, 2'b10);
        check("recover_alive", alive, 1);

        step(0, 1);
        check("clear_fault_cnt", fault_cnt, 0);
        check("clear_alive", alive, 0);

        // clear_fault wins over a same-cycle tick
        step(1, 1);
        check("clr_tick_pv", period_valid, 0);
        check("clr_tick_alive", alive, 0);

        // Two-cycle tick -> period 1, early
        gap_tick(20);
        gap_tick(100);
        step(1, 0);
        check("dbl_period", period_out, 1);
        check("dbl_early", early_err, 1);

        // Period statistics
        step(0, 1);
        gap_tick(10);
        gap_tick(98);
        gap_tick(103);
        gap_tick(100);
`ifdef TICK_MON_STATS_EN
        check("stats_min", period_min, 98);
        check("stats_max", period_max, 103);
`endif

        // fault_cnt saturation
        step(0, 1);
        gap_tick(5);
        repeat (260) gap_tick(2);
        check("fault_sat", fault_cnt, 255);

        // Async reset mid-gap
        gap_tick(100);
        repeat (50) step(0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outputs", {period_valid, early_err, late_err, alive, fault_cnt, period_out},
              44'd0);
        @(posedge clk);
        #1;
        check("arst_hold", {period_valid, early_err, late_err, alive, fault_cnt}, 12'd0);
        #2 rst_n = 1'b1;
        model_reset();
        nlate = 0;
        for (int k = 0; k < 150; k++) begin
            step(0, 0);
            if (period_valid | late_err | early_err) nlate++;
        end
        check("arst_no_pulse", nlate, 0);

        // Randomised gaps with occasional clears
        for (int r = 0; r < 70; r++) begin
            case ($urandom_range(0, 9))
                0:       g = $urandom_range(200, 450);
                1:       g = $urandom_range(1, 4);
                default: g = $urandom_range(85, 120);
            endcase
            for (int j = 0; j < g - 1; j++) step(0, ($urandom_range(0, 299) == 0));
            step(1, ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
